// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if -- host write port of the display scan controller.
//
// Carries the four BCD digit values from the host register logic into the
// scan controller with a valid/ready handshake.
//   wr_valid  host -> block   write request
//   wr_ready  block -> host   block can accept a write
//   wr_data   host -> block   digit values, [3:0] digit 0 .. [15:12] digit 3
//
// Modports: master = host side, slave = scan controller side.
interface seg_scan_ctrl_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- 4-digit multiplexed 7-segment scan controller.
//
// Holds four BCD digits behind a valid/ready write port (shadow/active double
// buffer, committed at frame boundaries), scans them onto a shared BCD bus
// with active-low one-hot anode enables, and applies per-slot brightness PWM
// with phase 0 of every slot kept dark as a ghosting guard.
//
// Timing: one PWM phase = PHASE_CYC cycles, one slot = 8 phases,
// one frame = 4 slots (digit 0 first).
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   wr          seg_scan_ctrl_if.slave write port (wr_valid/wr_ready/wr_data)
//   bright      brightness, lit phases per slot (0 = dark, 7 = 7/8 duty)
//   an          anode enables, active-low, at most one low
//   bcd         BCD code of the digit being scanned
//   frame_tick  one-cycle pulse in the first cycle of each frame
//
// Optional feature: define SEG_LZ_BLANK_EN for leading-zero blanking of
// digits 3..1 (bcd still driven, only the anode is suppressed).
module seg_scan_ctrl #(
  parameter int PHASE_CYC = 12500
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_ctrl_if.slave    wr,
  input  logic [2:0]        bright,
  output logic [3:0]        an,
  output logic [3:0]        bcd,
  output logic              frame_tick
);

  localparam int CW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(PHASE_CYC - 1);

  logic [CW-1:0] cyc_reg, cyc_next;
  logic [2:0]    phase_reg, phase_next;
  logic [1:0]    sel_reg, sel_next;
  logic [15:0]   active_reg, active_next;
  logic [15:0]   shadow_reg;
  logic          pending_reg;
  logic [2:0]    bright_q_reg;

  logic          cyc_wrap, slot_end, boundary, commit, accept;
  logic [3:0]    blank_next;
  logic [3:0]    an_next, bcd_next;

  assign wr.wr_ready = !pending_reg;

  always_comb begin
    cyc_wrap    = (cyc_reg == CYC_LAST);
    slot_end    = cyc_wrap && (phase_reg == 3'd7);
    boundary    = slot_end && (sel_reg == 2'd3);
    cyc_next    = cyc_wrap ? '0 : cyc_reg + CW'(1);
    phase_next  = cyc_wrap ? phase_reg + 3'd1 : phase_reg;
    sel_next    = slot_end ? sel_reg + 2'd1 : sel_reg;
    // accept needs !pending and commit needs pending, so they never coincide;
    // a write taken on the boundary cycle therefore waits a full frame.
    commit      = boundary && pending_reg;
    accept      = wr.wr_valid && !pending_reg;
    active_next = commit ? shadow_reg : active_reg;
  end

`ifdef SEG_LZ_BLANK_EN
  // Digit k is blanked when it and every more-significant digit are zero.
  assign blank_next[0] = 1'b0;
  for (genvar gi = 1; gi < 4; gi++) begin : g_lz
    assign blank_next[gi] = (active_next[15:4*gi] == '0);
  end
`else
  assign blank_next = 4'b0000;
`endif

  // Outputs are registered from the next counter/buffer state so that they
  // line up with the counters: the first cycle of a frame shows frame_tick
  // together with the freshly committed digit 0 on bcd.
  always_comb begin
    bcd_next = active_next[{sel_next, 2'b00} +: 4];
    an_next  = 4'hF;
    // bright_q_reg is stable here: it only changes entering phase 0.
    if (phase_next != 3'd0 && phase_next <= bright_q_reg && !blank_next[sel_next])
      an_next[sel_next] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_reg      <= '0;
      phase_reg    <= '0;
      sel_reg      <= '0;
      active_reg   <= '0;
      shadow_reg   <= '0;
      pending_reg  <= 1'b0;
      bright_q_reg <= '0;
      an           <= 4'hF;
      bcd          <= 4'h0;
      frame_tick   <= 1'b0;
    end else begin
      cyc_reg    <= cyc_next;
      phase_reg  <= phase_next;
      sel_reg    <= sel_next;
      active_reg <= active_next;
      if (commit) begin
        pending_reg <= 1'b0;
      end else if (accept) begin
        shadow_reg  <= wr.wr_data;
        pending_reg <= 1'b1;
      end
      // Loaded at the slot edge so it holds the new slot's brightness from
      // the slot's first cycle; the slot right after reset stays dark.
      if (slot_end)
        bright_q_reg <= bright;
      an         <= an_next;
      bcd        <= bcd_next;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
  localparam int PC    = 4;
  localparam int SLOT  = 8 * PC;
  localparam int FRAME = 4 * SLOT;
`ifdef SEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] bright;
  logic [3:0] an, bcd;
  logic       frame_tick;

  seg_scan_ctrl_if wr_if ();

  seg_scan_ctrl #(.PHASE_CYC(PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr_if),
    .bright     (bright),
    .an         (an),
    .bcd        (bcd),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit blanked(int k, logic [15:0] act);
    return LZ && (k > 0) && ((act >> (4 * k)) == 16'h0);
  endfunction

  // Behavioural model: position in the scan is derived from the cycle count
  // since reset; buffers follow the write/commit rules.
  int          m_n;
  bit          m_on = 1'b0;
  logic [15:0] m_active, m_shadow;
  bit          m_pending;
  int          m_bq;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_on = 1'b1; m_n = 0; m_active = '0; m_shadow = '0;
        m_pending = 1'b0; m_bq = 0;
      end else if (m_on) begin
        int phase, sel;
        logic [3:0] e_an;
        phase = (m_n / PC) % 8;
        sel   = (m_n / SLOT) % 4;
        e_an  = 4'hF;
        if (phase >= 1 && phase <= m_bq && !blanked(sel, m_active)) e_an[sel] = 1'b0;
        chk($sformatf("an n=%0d", m_n), {12'h0, an}, {12'h0, e_an});
        chk($sformatf("bcd n=%0d", m_n), {12'h0, bcd}, (m_active >> (4 * sel)) & 16'hF);
        chk($sformatf("frame_tick n=%0d", m_n), {15'h0, frame_tick},
            {15'h0, (m_n > 0 && m_n % FRAME == 0)});
        chk($sformatf("wr_ready n=%0d", m_n), {15'h0, wr_if.wr_ready}, {15'h0, !m_pending});
        if (m_n % SLOT == SLOT - 1) m_bq = int'(bright);
        if (m_n % FRAME == FRAME - 1 && m_pending) begin
          m_active  = m_shadow;
          m_pending = 1'b0;
        end else if (wr_if.wr_valid && !m_pending) begin
          m_shadow  = wr_if.wr_data;
          m_pending = 1'b1;
        end
        m_n++;
      end
    end
  end

  int cur;
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
    cur += k;
  endtask
  task automatic go(input int target);
    step(target - cur);
  endtask
  task automatic write(input logic [15:0] d);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    step(1);
    wr_if.wr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bright = 3'd7; wr_if.wr_valid = 1'b0; wr_if.wr_data = '0; cur = 0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; cur = 0;
    chk("reset an", {12'h0, an}, 16'h000F);
    chk("reset bcd", {12'h0, bcd}, 16'h0000);
    chk("reset wr_ready", {15'h0, wr_if.wr_ready}, 16'h0001);
    chk("reset frame_tick", {15'h0, frame_tick}, 16'h0000);
    go(4);   chk("slot0 dark after reset", {12'h0, an}, 16'h000F);
    go(36);  chk("slot1 lit", {12'h0, an}, 16'h000D);
    go(128); chk("first frame_tick", {15'h0, frame_tick}, 16'h0001);
    go(168); write(16'h4321);
    chk("wr_ready low after write", {15'h0, wr_if.wr_ready}, 16'h0000);
    go(256);
    chk("tick at commit", {15'h0, frame_tick}, 16'h0001);
    chk("bcd digit0 new", {12'h0, bcd}, 16'h0001);
    chk("wr_ready after commit", {15'h0, wr_if.wr_ready}, 16'h0001);
    go(324); chk("bcd digit2", {12'h0, bcd}, 16'h0003);
    go(383); write(16'h8765);
    chk("boundary write old bcd", {12'h0, bcd}, 16'h0001);
    chk("boundary write pending", {15'h0, wr_if.wr_ready}, 16'h0000);
    go(512); chk("boundary write visible", {12'h0, bcd}, 16'h0005);
    go(552); bright = 3'd2;
    go(572); chk("slot1 keeps duty", {12'h0, an}, 16'h000D);
    go(581); chk("slot2 phase1 lit", {12'h0, an}, 16'h000B);
    go(590); chk("slot2 phase3 dark", {12'h0, an}, 16'h000F);
    go(600); bright = 3'd0;
    go(610); bright = 3'd7;
    go(620); write(16'h0050);
    go(628); chk("bright0 slot dark", {12'h0, an}, 16'h000F);
    go(676); chk("digit1 lit", {12'h0, an}, 16'h000D);
    go(708); chk("digit2 blank rule", {12'h0, an}, LZ ? 16'h000F : 16'h000B);
    chk("digit2 bcd still driven", {12'h0, bcd}, 16'h0000);
    go(835); write(16'h1234);
    go(840); rst = 1'b1;
    step(1); rst = 1'b0; cur = 0;
    chk("mid reset an", {12'h0, an}, 16'h000F);
    chk("mid reset bcd", {12'h0, bcd}, 16'h0000);
    chk("mid reset wr_ready", {15'h0, wr_if.wr_ready}, 16'h0001);
    go(36);  chk("restart slot1 lit", {12'h0, an}, 16'h000D);
    go(128); chk("restart frame_tick", {15'h0, frame_tick}, 16'h0001);
    chk("active cleared", {12'h0, bcd}, 16'h0000);
    go(200);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
